// File: rtl/regional_max_pkg.sv
// Shared types and sizing for the regional-maximum accelerator.
// Image geometry, pixel/address types and the engine state encoding.
package regional_max_pkg;

   localparam int M            = 4;
   localparam int N            = 4;
   localparam int PIXEL_WIDTH  = 8;
   localparam int WINDOW_WIDTH = 3;
   localparam int I_WIDTH      = 2;
   localparam int J_WIDTH      = 2;
   localparam int ADDR_WIDTH   = I_WIDTH + J_WIDTH;

   typedef logic [PIXEL_WIDTH-1:0] pixel_t;

   typedef struct packed {
      logic [I_WIDTH-1:0] i;
      logic [J_WIDTH-1:0] j;
   } addr_t;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      PASS,
      CHECK,
      DONE
   } state_t;

endpackage

// File: rtl/regional_max_pixel_ram.sv
// MxN pixel register file with one write port and a 3x3 window read
// around (i,j); taps falling outside the image are flagged invalid.
module regional_max_pixel_ram
   import regional_max_pkg::*;
(
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                we_i,
   input  addr_t                               waddr_i,
   input  pixel_t                              wdata_i,
   input  addr_t                               raddr_i,
   output pixel_t [WINDOW_WIDTH-1:0][WINDOW_WIDTH-1:0] win_o,
   output logic   [WINDOW_WIDTH-1:0][WINDOW_WIDTH-1:0] vld_o
);

   pixel_t [M-1:0][N-1:0] img_q;
   int ni;
   int nj;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         img_q <= '0;
      end else if (we_i) begin
         img_q[waddr_i.i][waddr_i.j] <= wdata_i;
      end
   end

   always_comb begin
      win_o = '0;
      vld_o = '0;
      ni    = 0;
      nj    = 0;
      for (int a = 0; a < WINDOW_WIDTH; a++) begin
         for (int b = 0; b < WINDOW_WIDTH; b++) begin
            ni = int'(raddr_i.i) + a - 1;
            nj = int'(raddr_i.j) + b - 1;
            if (ni >= 0 && ni < M && nj >= 0 && nj < N) begin
               vld_o[a][b] = 1'b1;
               win_o[a][b] = img_q[I_WIDTH'(ni)][J_WIDTH'(nj)];
            end
         end
      end
   end

endmodule

// File: rtl/regional_max_engine.sv
// Regional-maximum engine: iterative flag relaxation over the pixel RAM
// with alternating raster sweeps until a sweep clears no flag.
module regional_max_engine
   import regional_max_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [PIXEL_WIDTH-1:0] pixel_in,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic                  write_en,
   input  logic                  start,
   output logic                  done,
   output logic [M-1:0][N-1:0]   matrix_output
);

   state_t state_q, state_d;
   addr_t  pos_q, pos_d;
   logic   fwd_q, fwd_d;
   logic   chg_q, chg_d;
   logic [3:0] npass_q, npass_d;
   logic [M-1:0][N-1:0] flags_q, flags_d;
   logic [M-1:0][N-1:0] mout_q, mout_d;
   logic   done_q, done_d;

   addr_t  waddr;
   logic   we;
   logic   clr;
   int     ni;
   int     nj;
   pixel_t ctr;

   pixel_t [WINDOW_WIDTH-1:0][WINDOW_WIDTH-1:0] win;
   logic   [WINDOW_WIDTH-1:0][WINDOW_WIDTH-1:0] vld;

   assign waddr = addr_t'(wr_addr);
   assign we    = write_en
                && (state_q == IDLE || state_q == DONE)
                && (32'(waddr.i) < 32'(M))
                && (32'(waddr.j) < 32'(N));

   regional_max_pixel_ram u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (pixel_in),
      .raddr_i (pos_q),
      .win_o   (win),
      .vld_o   (vld)
   );

   // A pixel loses its flag to a higher neighbour or an equal, unflagged one.
   always_comb begin
      clr = 1'b0;
      ni  = 0;
      nj  = 0;
      ctr = win[1][1];
      for (int a = 0; a < WINDOW_WIDTH; a++) begin
         for (int b = 0; b < WINDOW_WIDTH; b++) begin
            ni = int'(pos_q.i) + a - 1;
            nj = int'(pos_q.j) + b - 1;
            if (!(a == 1 && b == 1) && vld[a][b]) begin
               if (win[a][b] > ctr) begin
                  clr = 1'b1;
               end else if (win[a][b] == ctr &&
                            !flags_q[I_WIDTH'(ni)][J_WIDTH'(nj)]) begin
                  clr = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pos_q   <= '0;
         fwd_q   <= 1'b1;
         chg_q   <= 1'b0;
         npass_q <= '0;
         flags_q <= '0;
         mout_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         fwd_q   <= fwd_d;
         chg_q   <= chg_d;
         npass_q <= npass_d;
         flags_q <= flags_d;
         mout_q  <= mout_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      fwd_d   = fwd_q;
      chg_d   = chg_q;
      npass_d = npass_q;
      flags_d = flags_q;
      mout_d  = mout_q;
      done_d  = done_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = INIT;
               done_d  = 1'b0;
            end
         end
         INIT: begin
            flags_d = '1;
            pos_d   = '0;
            fwd_d   = 1'b1;
            chg_d   = 1'b0;
            npass_d = '0;
            state_d = PASS;
         end
         PASS: begin
            if (clr && flags_q[pos_q.i][pos_q.j]) begin
               flags_d[pos_q.i][pos_q.j] = 1'b0;
               chg_d = 1'b1;
            end
            if (fwd_q) begin
               if (pos_q.j == J_WIDTH'(N-1)) begin
                  pos_d.j = '0;
                  pos_d.i = pos_q.i + 1'b1;
                  if (pos_q.i == I_WIDTH'(M-1)) begin
                     state_d = CHECK;
                  end
               end else begin
                  pos_d.j = pos_q.j + 1'b1;
               end
            end else begin
               if (pos_q.j == '0) begin
                  pos_d.j = J_WIDTH'(N-1);
                  pos_d.i = pos_q.i - 1'b1;
                  if (pos_q.i == '0) begin
                     state_d = CHECK;
                  end
               end else begin
                  pos_d.j = pos_q.j - 1'b1;
               end
            end
            if (state_d == CHECK && npass_q != '1) begin
               npass_d = npass_q + 1'b1;
            end
         end
         CHECK: begin
            if (chg_q || npass_q < 4'd2) begin
               state_d = PASS;
               chg_d   = 1'b0;
               fwd_d   = !fwd_q;
               if (fwd_q) begin
                  pos_d.i = I_WIDTH'(M-1);
                  pos_d.j = J_WIDTH'(N-1);
               end else begin
                  pos_d = '0;
               end
            end else begin
               state_d = DONE;
               mout_d  = flags_q;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign done          = done_q;
   assign matrix_output = mout_q;

endmodule

// File: tb/tb_regional_max_engine.sv
// Directed bench for regional_max_engine: vector table of 4x4 images
// with hand-derived masks, plus restart, busy-write and reset sequences.
module tb_regional_max_engine;

   logic        clk;
   logic        reset_n;
   logic [7:0]  pixel_in;
   logic [3:0]  wr_addr;
   logic        write_en;
   logic        start;
   logic        done;
   logic [3:0][3:0] matrix_output;

   int checks;
   int errors;

   typedef struct {
      logic [15:0][7:0] img;
      logic [15:0]      exp;
   } vec_t;

   vec_t vecs [7];

   regional_max_engine dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pixel_in      (pixel_in),
      .wr_addr       (wr_addr),
      .write_en      (write_en),
      .start         (start),
      .done          (done),
      .matrix_output (matrix_output)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wr(input int k, input logic [7:0] v);
      write_en = 1'b1;
      wr_addr  = 4'(k);
      pixel_in = v;
      tick();
      write_en = 1'b0;
   endtask

   task automatic load(input logic [15:0][7:0] img);
      for (int k = 0; k < 16; k++) wr(k, img[k]);
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, output int cyc);
      cyc = 0;
      while (!done && cyc < 300) begin
         tick();
         cyc++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s: done not seen, got %0d cycles required <=300",
                  name, cyc);
      end
   endtask

   initial begin
      int cyc;
      logic [15:0][7:0] im;
      checks   = 0;
      errors   = 0;
      reset_n  = 1'b0;
      pixel_in = '0;
      wr_addr  = '0;
      write_en = 1'b0;
      start    = 1'b0;

      // single peak
      vecs[0].img = '0;
      vecs[0].img[5] = 8'd9;
      vecs[0].exp = 16'h0020;
      // flat
      for (int k = 0; k < 16; k++) vecs[1].img[k] = 8'd5;
      vecs[1].exp = 16'hFFFF;
      // 2x2 plateau plus corner peak
      for (int k = 0; k < 16; k++) vecs[2].img[k] = 8'd1;
      vecs[2].img[0]  = 8'd5;
      vecs[2].img[1]  = 8'd5;
      vecs[2].img[4]  = 8'd5;
      vecs[2].img[5]  = 8'd5;
      vecs[2].img[15] = 8'd7;
      vecs[2].exp = 16'h8033;
      // plateau beaten by a higher neighbour
      vecs[3].img = '0;
      vecs[3].img[0] = 8'd5;
      vecs[3].img[1] = 8'd5;
      vecs[3].img[2] = 8'd5;
      vecs[3].img[3] = 8'd6;
      vecs[3].exp = 16'h0008;
      // ramp
      for (int k = 0; k < 16; k++) vecs[4].img[k] = 8'(k);
      vecs[4].exp = 16'h8000;
      // two corner peaks
      for (int k = 0; k < 16; k++) vecs[5].img[k] = 8'd2;
      vecs[5].img[0]  = 8'd3;
      vecs[5].img[15] = 8'd3;
      vecs[5].exp = 16'h8001;
      // border ring plateau around a low centre
      for (int k = 0; k < 16; k++) vecs[6].img[k] = 8'd4;
      vecs[6].img[5]  = 8'd1;
      vecs[6].img[6]  = 8'd1;
      vecs[6].img[9]  = 8'd1;
      vecs[6].img[10] = 8'd1;
      vecs[6].exp = 16'hF99F;

      tick();
      tick();
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_mask", 32'(matrix_output), 32'h0);
      reset_n = 1'b1;
      tick();

      for (int v = 0; v < 7; v++) begin
         load(vecs[v].img);
         go();
         chk($sformatf("vec%0d_done_drop", v), 32'(done), 32'd0);
         wait_done($sformatf("vec%0d_wait", v), cyc);
         chk($sformatf("vec%0d_mask", v), 32'(matrix_output),
             32'(vecs[v].exp));
         if (v == 1) begin
            chk("flat_latency_ok", 32'(cyc <= 300), 32'd1);
         end
         tick();
      end

      // rerun on the stored ring image without reloading
      go();
      chk("rerun_done_drop", 32'(done), 32'd0);
      wait_done("rerun_wait", cyc);
      chk("rerun_mask", 32'(matrix_output), 32'hF99F);

      // writes during BUSY are dropped
      load(vecs[0].img);
      go();
      tick();
      tick();
      wr(10, 8'd50);
      wr(0, 8'd77);
      wait_done("busywr_wait", cyc);
      chk("busywr_mask", 32'(matrix_output), 32'h0020);
      go();
      wait_done("busywr_rerun_wait", cyc);
      chk("busywr_rerun_mask", 32'(matrix_output), 32'h0020);

      // reset while busy
      go();
      tick();
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      chk("midreset_done", 32'(done), 32'd0);
      chk("midreset_mask", 32'(matrix_output), 32'h0);
      reset_n = 1'b1;
      tick();
      go();
      wait_done("zeroimg_wait", cyc);
      chk("zeroimg_mask", 32'(matrix_output), 32'hFFFF);

      // write and start in the same IDLE cycle
      reset_n = 1'b0;
      tick();
      reset_n  = 1'b1;
      tick();
      write_en = 1'b1;
      wr_addr  = 4'd11;
      pixel_in = 8'd7;
      start    = 1'b1;
      tick();
      write_en = 1'b0;
      start    = 1'b0;
      wait_done("wrstart_wait", cyc);
      chk("wrstart_mask", 32'(matrix_output), 32'h0800);

      // flat image of a different value holds across idle cycles
      im = '0;
      for (int k = 0; k < 16; k++) im[k] = 8'd200;
      load(im);
      go();
      wait_done("flat200_wait", cyc);
      for (int k = 0; k < 3; k++) tick();
      chk("flat200_hold_done", 32'(done), 32'd1);
      chk("flat200_mask", 32'(matrix_output), 32'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
